// File: rtl/sa_sched_pkg.sv
// Shared types and helpers for the systolic-array job scheduler.
package sa_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        DONE
    } sched_state_t;

    // Widest requester vector the onehot helper can build; callers truncate to their own width.
    localparam int MAX_REQ = 32;

    localparam int DEFAULT_N_SIZE = 5;

    function automatic int array_ticks(input int n_size);
        return 3 * n_size - 2;
    endfunction

    localparam int ARRAY_TICKS = array_ticks(DEFAULT_N_SIZE);

    function automatic logic [MAX_REQ-1:0] onehot(input int idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/sa_job_scheduler_if.sv
// Requester-facing bundle of the job scheduler: level requests in, ownership and job status out.
interface sa_job_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int N_SIZE  = 5
);
    import sa_sched_pkg::*;

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int TICK_W = $clog2(array_ticks(N_SIZE) + 1);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    owner_id;
    logic               start;
    logic               busy;
    logic [NUM_REQ-1:0] done;
    logic [TICK_W-1:0]  tick;

    modport master (
        input  req,
        output gnt,
        output owner_id,
        output start,
        output busy,
        output done,
        output tick
    );

    modport slave (
        output req,
        input  gnt,
        input  owner_id,
        input  start,
        input  busy,
        input  done,
        input  tick
    );

endinterface

// File: rtl/sa_rr_picker.sv
// Combinational rotating-priority picker: first set request at or above rr_ptr, wrapping around.
module sa_rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               any_req,
    output logic [ID_W-1:0]    winner
);

    // Scan from the farthest offset down so the nearest requester to rr_ptr is written last and wins.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if ((req & (NUM_REQ'(1) << idx)) != '0) begin
                any_req = 1'b1;
                winner  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sa_job_scheduler.sv
// Shares one systolic array between several requesters: round-robin pick, start pulse,
// ownership for the whole array pipeline, then a done pulse back to the owner.
module sa_job_scheduler
    import sa_sched_pkg::*;
#(
    parameter int N_SIZE  = 5,
    parameter int NUM_REQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sa_job_scheduler_if.master    bus
);

    localparam int ID_W        = $clog2(NUM_REQ);
    localparam int JOB_TICKS   = array_ticks(N_SIZE);
    localparam int TICK_W      = $clog2(JOB_TICKS + 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(JOB_TICKS - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

    sched_state_t    state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner;
    logic            any_req;

    sa_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .any_req (any_req),
        .winner  (winner)
    );

    // Every output is a register; req only reaches the state through the picker in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            bus.gnt      <= '0;
            bus.owner_id <= '0;
            bus.start    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= '0;
            bus.tick     <= '0;
        end else begin
            bus.start <= 1'b0;
            bus.done  <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.owner_id <= winner;
                        bus.gnt      <= NUM_REQ'(onehot(int'(winner)));
                        bus.start    <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    bus.tick <= '0;
                    state    <= BUSY;
                end
                BUSY: begin
                    if (bus.tick == LAST_TICK) begin
                        bus.tick <= '0;
                        bus.done <= NUM_REQ'(onehot(int'(bus.owner_id)));
                        state    <= DONE;
                    end else begin
                        bus.tick <= bus.tick + TICK_W'(1);
                    end
                end
                DONE: begin
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    // Explicit wrap keeps rr_ptr below NUM_REQ when it is not a power of two.
                    rr_ptr   <= (bus.owner_id == LAST_ID) ? '0 : bus.owner_id + ID_W'(1);
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_job_scheduler.sv
// Scoreboard bench for sa_job_scheduler: directed jobs push expected start/done events,
// a monitor pops and compares them whenever the scheduler pulses start or done.
module tb_sa_job_scheduler;

    localparam int NUM_REQ = 4;
    localparam int N_SIZE  = 5;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
        int         id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   base;

    exp_t start_q[$];
    exp_t done_q[$];

    sa_job_scheduler_if #(.NUM_REQ(NUM_REQ), .N_SIZE(N_SIZE)) bus();

    sa_job_scheduler #(
        .N_SIZE  (N_SIZE),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic rs);
        bus.req = r;
        rst     = rs;
    endtask

    // Job of length 13 busy cycles: done lands 14 cycles after its start pulse.
    task automatic pushJob(input int start_cyc, input int id, input bit with_done);
        exp_t e;
        e.cyc = start_cyc;
        e.vec = 4'(1 << id);
        e.id  = id;
        start_q.push_back(e);
        if (with_done) begin
            e.cyc = start_cyc + 14;
            done_q.push_back(e);
        end
    endtask

    // Monitor: compares every start/done pulse against the scoreboard, plus the invariants.
    initial begin
        exp_t e;
        logic prev_start;
        prev_start = 1'b0;
        @(negedge clk);
        forever begin
            if (bus.start === 1'b1) begin
                if (start_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL start_unexpected: got start owner %0d expected none at cycle %0d",
                             bus.owner_id, cyc);
                end else begin
                    e = start_q.pop_front();
                    checkOutput("start_cycle", cyc, e.cyc);
                    checkOutput("start_gnt", 32'(bus.gnt), 32'(e.vec));
                    checkOutput("start_owner", 32'(bus.owner_id), e.id);
                end
            end
            if (bus.done !== 4'b0000) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL done_unexpected: got done %b expected none at cycle %0d",
                             bus.done, cyc);
                end else begin
                    e = done_q.pop_front();
                    checkOutput("done_cycle", cyc, e.cyc);
                    checkOutput("done_vec", 32'(bus.done), 32'(e.vec));
                end
            end
            checkOutput("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
            checkOutput("start_back_to_back", 32'(prev_start & bus.start), 0);
            prev_start = bus.start;
            @(negedge clk);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish expected finish by 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(4'b1111, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_gnt", 32'(bus.gnt), 0);
            checkOutput("rst_start", 32'(bus.start), 0);
            checkOutput("rst_busy", 32'(bus.busy), 0);
            checkOutput("rst_done", 32'(bus.done), 0);
            checkOutput("rst_tick", 32'(bus.tick), 0);
            checkOutput("rst_owner", 32'(bus.owner_id), 0);
        end

        // Round-robin with all requesters held: owners 0,1,2,3,0 every 16 cycles.
        applyStimulus(4'b1111, 1'b0);
        base = cyc;
        for (int k = 0; k < 5; k++) begin
            pushJob(base + 1 + 16 * k, k % 4, 1'b1);
        end
        repeat (65) @(negedge clk);
        applyStimulus(4'b0000, 1'b0);
        repeat (16) @(negedge clk);

        // Single job from requester 2 with cycle-by-cycle busy/gnt/tick profile.
        base = cyc;
        applyStimulus(4'b0100, 1'b0);
        pushJob(base + 1, 2, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checkOutput("single_busy", 32'(bus.busy), (k <= 15) ? 1 : 0);
            checkOutput("single_gnt", 32'(bus.gnt), (k <= 15) ? 4 : 0);
            checkOutput("single_tick", 32'(bus.tick), (k >= 2 && k <= 14) ? k - 2 : 0);
            if (k == 1) applyStimulus(4'b0000, 1'b0);
        end

        // rr_ptr is now 3: requests 0 and 1 wrap to owner 0 first, then 1.
        base = cyc;
        applyStimulus(4'b0011, 1'b0);
        pushJob(base + 1, 0, 1'b1);
        pushJob(base + 17, 1, 1'b1);
        repeat (17) @(negedge clk);
        applyStimulus(4'b0000, 1'b0);
        repeat (16) @(negedge clk);

        // Requester 1 drops its request mid-job; the job still completes.
        base = cyc;
        applyStimulus(4'b0010, 1'b0);
        pushJob(base + 1, 1, 1'b1);
        repeat (5) @(negedge clk);
        applyStimulus(4'b0000, 1'b0);
        repeat (11) @(negedge clk);

        // Reset at tick 6 aborts the job silently; a fresh job follows after release.
        base = cyc;
        applyStimulus(4'b0001, 1'b0);
        pushJob(base + 1, 0, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("midrst_tick_before", 32'(bus.tick), 6);
        applyStimulus(4'b0001, 1'b1);
        @(negedge clk);
        checkOutput("midrst_busy", 32'(bus.busy), 0);
        checkOutput("midrst_gnt", 32'(bus.gnt), 0);
        checkOutput("midrst_tick", 32'(bus.tick), 0);
        checkOutput("midrst_start", 32'(bus.start), 0);
        checkOutput("midrst_done", 32'(bus.done), 0);
        applyStimulus(4'b0001, 1'b0);
        pushJob(base + 10, 0, 1'b1);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0);
        repeat (16) @(negedge clk);

        for (int i = 0; i < 50 && (start_q.size() != 0 || done_q.size() != 0); i++) begin
            @(negedge clk);
        end
        checkOutput("start_q_left", start_q.size(), 0);
        checkOutput("done_q_left", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
